// File: rtl/pipe_ctrl_unit.sv
// ID-stage main control for the 5-stage RV32 pipe: decode into the ID/EX control slice (1 cycle),
// load-use bubble insertion (stall is combinational), flush kill, saturating event counters.
module pipe_ctrl_unit #(
   parameter int OPW      = 5,
   parameter int REGW     = 5,
   parameter bit EN_ITYPE = 1'b1,
   parameter bit EN_JUMP  = 1'b1,
   parameter int CNTW     = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [OPW-1:0]  id_opcode,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic            flush,
   output logic            stall,
   output logic            ex_valid,
   output logic            ex_branch,
   output logic            ex_memread,
   output logic            ex_memtoreg,
   output logic            ex_memwrite,
   output logic            ex_alusrc,
   output logic            ex_regwrite,
   output logic            ex_jump,
   output logic [1:0]      ex_aluop,
   output logic [REGW-1:0] ex_rd,
   output logic            illegal,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] flush_cnt,
   output logic [CNTW-1:0] illegal_cnt
);

   typedef struct packed {
      logic       branch;
      logic       memread;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regwrite;
      logic       jump;
      logic [1:0] aluop;
   } ctrl_t;

   localparam logic [OPW-1:0] OP_R      = OPW'(5'b01100);
   localparam logic [OPW-1:0] OP_LOAD   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OP_STORE  = OPW'(5'b01000);
   localparam logic [OPW-1:0] OP_BRANCH = OPW'(5'b11000);
   localparam logic [OPW-1:0] OP_ITYPE  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_JAL    = OPW'(5'b11011);
   localparam logic [OPW-1:0] OP_JALR   = OPW'(5'b11001);

   ctrl_t dec;
   ctrl_t ex_q;
   logic  dec_illegal;
   logic  uses_rs1;
   logic  uses_rs2;
   logic  haz;
   logic  load_en;
   logic  ill_nxt;

   always_comb begin
      dec         = '0;
      dec_illegal = 1'b0;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
      case (id_opcode)
         OP_R: begin
            dec.regwrite = 1'b1;
            dec.aluop    = 2'b10;
            uses_rs1     = 1'b1;
            uses_rs2     = 1'b1;
         end
         OP_LOAD: begin
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            uses_rs1     = 1'b1;
         end
         OP_STORE: begin
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
            uses_rs1     = 1'b1;
            uses_rs2     = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch = 1'b1;
            dec.aluop  = 2'b01;
            uses_rs1   = 1'b1;
            uses_rs2   = 1'b1;
         end
         OP_ITYPE: begin
            if (EN_ITYPE) begin
               dec.alusrc   = 1'b1;
               dec.regwrite = 1'b1;
               dec.aluop    = 2'b11;
               uses_rs1     = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OP_JAL: begin
            // JAL reads no source register, so it can never be a load-use victim
            if (EN_JUMP) begin
               dec.regwrite = 1'b1;
               dec.jump     = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OP_JALR: begin
            if (EN_JUMP) begin
               dec.alusrc   = 1'b1;
               dec.regwrite = 1'b1;
               dec.jump     = 1'b1;
               uses_rs1     = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign haz = ex_valid & ex_q.memread & (ex_rd != '0) & id_valid &
                ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));
   assign stall   = haz & ~flush;
   assign load_en = ~flush & ~haz & id_valid & ~dec_illegal;
   assign ill_nxt = id_valid & dec_illegal & ~flush & ~haz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_q        <= '0;
         ex_rd       <= '0;
         illegal     <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         illegal_cnt <= '0;
      end else begin
         ex_valid <= load_en;
         ex_q     <= load_en ? dec : '0;
         ex_rd    <= load_en ? id_rd : '0;
         illegal  <= ill_nxt;
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNTW'(1);
         if (flush && id_valid && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNTW'(1);
         if (ill_nxt && (illegal_cnt != '1))
            illegal_cnt <= illegal_cnt + CNTW'(1);
      end
   end

   assign ex_branch   = ex_q.branch;
   assign ex_memread  = ex_q.memread;
   assign ex_memtoreg = ex_q.memtoreg;
   assign ex_memwrite = ex_q.memwrite;
   assign ex_alusrc   = ex_q.alusrc;
   assign ex_regwrite = ex_q.regwrite;
   assign ex_jump     = ex_q.jump;
   assign ex_aluop    = ex_q.aluop;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench: driver pushes hand-computed expectations per cycle, monitor pops and compares.
// A second instance (no jumps, 2-bit counters) shares the stimulus to cover illegal JAL/JALR and saturation.
module tb_pipe_ctrl_unit;

   localparam logic [8:0] C_Z  = 9'b000000000;
   localparam logic [8:0] C_R  = 9'b000001010;
   localparam logic [8:0] C_LD = 9'b011011000;
   localparam logic [8:0] C_ST = 9'b000110000;
   localparam logic [8:0] C_BR = 9'b100000001;
   localparam logic [8:0] C_IT = 9'b000011011;
   localparam logic [8:0] C_JL = 9'b000001100;
   localparam logic [8:0] C_JR = 9'b000011100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_opcode = '0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic [4:0] id_rd = '0;
   logic       flush = 1'b0;

   logic        stall, ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
   logic        ex_alusrc, ex_regwrite, ex_jump, illegal;
   logic [1:0]  ex_aluop;
   logic [4:0]  ex_rd;
   logic [15:0] stall_cnt, flush_cnt, illegal_cnt;

   logic        u2_stall, u2_valid, u2_branch, u2_memread, u2_memtoreg, u2_memwrite;
   logic        u2_alusrc, u2_regwrite, u2_jump, u2_illegal;
   logic [1:0]  u2_aluop;
   logic [4:0]  u2_rd;
   logic [1:0]  u2_stall_cnt, u2_flush_cnt, u2_illegal_cnt;

   always #5 clk = ~clk;

   pipe_ctrl_unit dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .stall(stall), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memread(ex_memread),
      .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
      .ex_regwrite(ex_regwrite), .ex_jump(ex_jump), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
      .illegal(illegal), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .illegal_cnt(illegal_cnt)
   );

   pipe_ctrl_unit #(.EN_JUMP(1'b0), .CNTW(2)) u2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .stall(u2_stall), .ex_valid(u2_valid), .ex_branch(u2_branch), .ex_memread(u2_memread),
      .ex_memtoreg(u2_memtoreg), .ex_memwrite(u2_memwrite), .ex_alusrc(u2_alusrc),
      .ex_regwrite(u2_regwrite), .ex_jump(u2_jump), .ex_aluop(u2_aluop), .ex_rd(u2_rd),
      .illegal(u2_illegal), .stall_cnt(u2_stall_cnt), .flush_cnt(u2_flush_cnt),
      .illegal_cnt(u2_illegal_cnt)
   );

   typedef struct packed {
      int          step;
      logic        stall;
      logic        exv;
      logic [8:0]  ctl;
      logic [4:0]  rd;
      logic        ill;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [15:0] ic;
      logic        uv;
      logic        ui;
      logic [1:0]  us;
      logic [1:0]  uic;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   step_no = 0;

   task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   // Expectation describes what the monitor sees during this cycle: stall for the
   // inputs just driven, registered outputs from the previous cycle's inputs.
   task automatic vec(input logic v, input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic fl, input logic st, input logic exv,
                      input logic [8:0] ctl, input logic [4:0] erd, input logic ill,
                      input int sc, input int fc, input int ic,
                      input logic uv, input logic ui, input int us, input int uic);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; flush = fl;
      e.step = step_no; e.stall = st; e.exv = exv; e.ctl = ctl; e.rd = erd; e.ill = ill;
      e.sc = 16'(sc); e.fc = 16'(fc); e.ic = 16'(ic);
      e.uv = uv; e.ui = ui; e.us = 2'(us); e.uic = 2'(uic);
      q.push_back(e);
      step_no++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", e.step, 32'(stall), 32'(e.stall));
            chk("ex_valid", e.step, 32'(ex_valid), 32'(e.exv));
            chk("ex_ctl", e.step, 32'({ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
                                       ex_alusrc, ex_regwrite, ex_jump, ex_aluop}), 32'(e.ctl));
            chk("ex_rd", e.step, 32'(ex_rd), 32'(e.rd));
            chk("illegal", e.step, 32'(illegal), 32'(e.ill));
            chk("stall_cnt", e.step, 32'(stall_cnt), 32'(e.sc));
            chk("flush_cnt", e.step, 32'(flush_cnt), 32'(e.fc));
            chk("illegal_cnt", e.step, 32'(illegal_cnt), 32'(e.ic));
            chk("u2_ex_valid", e.step, 32'(u2_valid), 32'(e.uv));
            chk("u2_illegal", e.step, 32'(u2_illegal), 32'(e.ui));
            chk("u2_stall_cnt", e.step, 32'(u2_stall_cnt), 32'(e.us));
            chk("u2_illegal_cnt", e.step, 32'(u2_illegal_cnt), 32'(e.uic));
         end
      end
   end

   initial begin : driver
      exp_t e;
      //   v  op        rs1 rs2 rd fl | st ev ctl   rd ill sc fc ic uv ui us uic
      vec(0, 5'b00000, 0,  0,  0, 0,   0, 0, C_Z,  0, 0,  0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      vec(1, 5'b01100, 1,  2,  3, 0,   0, 0, C_Z,  0, 0,  0, 0, 0, 0, 0, 0, 0);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 1, C_R,  3, 0,  0, 0, 0, 1, 0, 0, 0);
      vec(1, 5'b01100, 5,  7,  6, 0,   1, 1, C_LD, 5, 0,  0, 0, 0, 1, 0, 0, 0);
      vec(1, 5'b01100, 5,  7,  6, 0,   0, 0, C_Z,  0, 0,  1, 0, 0, 0, 0, 1, 0);
      vec(1, 5'b01000, 2,  3,  9, 0,   0, 1, C_R,  6, 0,  1, 0, 0, 1, 0, 1, 0);
      vec(1, 5'b11000, 1,  2,  4, 0,   0, 1, C_ST, 9, 0,  1, 0, 0, 1, 0, 1, 0);
      vec(1, 5'b00000, 1,  0,  0, 0,   0, 1, C_BR, 4, 0,  1, 0, 0, 1, 0, 1, 0);
      vec(1, 5'b01100, 0,  7,  6, 0,   0, 1, C_LD, 0, 0,  1, 0, 0, 1, 0, 1, 0);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 1, C_R,  6, 0,  1, 0, 0, 1, 0, 1, 0);
      vec(1, 5'b11011, 5,  5,  1, 0,   0, 1, C_LD, 5, 0,  1, 0, 0, 1, 0, 1, 0);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 1, C_JL, 1, 0,  1, 0, 0, 0, 1, 1, 1);
      vec(1, 5'b01000, 5,  9,  0, 0,   1, 1, C_LD, 5, 0,  1, 0, 0, 1, 0, 1, 1);
      vec(1, 5'b01000, 5,  9,  0, 0,   0, 0, C_Z,  0, 0,  2, 0, 0, 0, 0, 2, 1);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 1, C_ST, 0, 0,  2, 0, 0, 1, 0, 2, 1);
      vec(1, 5'b01100, 5,  7,  6, 1,   0, 1, C_LD, 5, 0,  2, 0, 0, 1, 0, 2, 1);
      vec(1, 5'b00100, 5,  0,  8, 0,   0, 0, C_Z,  0, 0,  2, 1, 0, 0, 0, 2, 1);
      vec(1, 5'b10100, 1,  2,  3, 0,   0, 1, C_IT, 8, 0,  2, 1, 0, 1, 0, 2, 1);
      vec(1, 5'b11001, 3,  0,  2, 0,   0, 0, C_Z,  0, 1,  2, 1, 1, 0, 1, 2, 2);
      vec(0, 5'b01100, 0,  0,  0, 0,   0, 1, C_JR, 2, 0,  2, 1, 1, 0, 1, 2, 3);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 0, C_Z,  0, 0,  2, 1, 1, 0, 0, 2, 3);
      vec(1, 5'b01100, 5,  7,  6, 0,   1, 1, C_LD, 5, 0,  2, 1, 1, 1, 0, 2, 3);
      vec(1, 5'b01100, 5,  7,  6, 0,   0, 0, C_Z,  0, 0,  3, 1, 1, 0, 0, 3, 3);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 1, C_R,  6, 0,  3, 1, 1, 1, 0, 3, 3);
      vec(1, 5'b01000, 5,  9,  0, 0,   1, 1, C_LD, 5, 0,  3, 1, 1, 1, 0, 3, 3);
      vec(1, 5'b01000, 5,  9,  0, 0,   0, 0, C_Z,  0, 0,  4, 1, 1, 0, 0, 3, 3);
      vec(1, 5'b00000, 1,  0,  5, 0,   0, 1, C_ST, 0, 0,  4, 1, 1, 1, 0, 3, 3);
      vec(1, 5'b01100, 5,  7,  6, 0,   1, 1, C_LD, 5, 0,  4, 1, 1, 1, 0, 3, 3);
      // Reset in the middle of the stall cycle, well before the next rising edge
      @(negedge clk);
      #2;
      e = '0;
      e.step = step_no;
      step_no++;
      q.push_back(e);
      rst_n = 1'b0;
      vec(1, 5'b01100, 5,  7,  6, 0,   0, 0, C_Z,  0, 0,  0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      vec(0, 5'b00000, 0,  0,  0, 0,   0, 1, C_R,  6, 0,  0, 0, 0, 1, 0, 0, 0);
      vec(0, 5'b00000, 0,  0,  0, 0,   0, 0, C_Z,  0, 0,  0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      #3;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined main control unit for the 5-stage RV32 core.
- Decodes opcode[6:2] of the ID-stage instruction into datapath controls and registers them into the ID/EX control slice.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles.
- Honours branch/jump flushes and keeps saturating stall/flush/illegal event counters.

Parameters:
- OPW, 5, opcode field width (instruction bits [6:2]).
- REGW, 5, register index width.
- EN_ITYPE, 1, when 1 decode I-type ALU (00100); when 0 treat it as illegal.
- EN_JUMP, 1, when 1 decode JAL (11011) and JALR (11001); when 0 treat them as illegal.
- CNTW, 16, width of each event counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  OPW  instruction bits [6:2].
- id_rs1  in  REGW  source register 1 index.
- id_rs2  in  REGW  source register 2 index.
- id_rd  in  REGW  destination register index.
- flush  in  1  branch/jump redirect from EX; kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX slot holds a real instruction.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_jump  out  1 each  registered controls.
- ex_aluop  out  2  registered ALU operation class.
- ex_rd  out  REGW  registered destination index.
- illegal  out  1  registered one-cycle pulse, undecodable valid instruction.
- stall_cnt, flush_cnt, illegal_cnt  out  CNTW each  saturating event counters.

Behaviour:
- Reset (rst_n=0, async): all registered outputs and counters are 0. The `stall` output is 0 because ex_valid=0.
- Decode table. Fields: Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, ALUOp.
  - 01100 R: 0 0 0 0 0 1 0 10
  - 00000 load: 0 1 1 0 1 1 0 00
  - 01000 store: 0 0 0 1 1 0 0 00
  - 11000 branch: 1 0 0 0 0 0 0 01
  - 00100 I-ALU (EN_ITYPE): 0 0 0 0 1 1 0 11
  - 11011 JAL (EN_JUMP): 0 0 0 0 0 1 1 00
  - 11001 JALR (EN_JUMP): 0 0 0 0 1 1 1 00
  - Any other opcode: all controls 0, dec_illegal=1.
- Source usage:
  - uses_rs1 = every legal opcode except JAL.
  - uses_rs2 = R, store, branch only.
- Hazard (combinational):
  - haz = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
  - stall = haz & ~flush.
- ID/EX update, every rising edge, priority order:
  1. flush: bubble.
  2. haz: bubble.
  3. ~id_valid or dec_illegal: bubble.
  4. Otherwise load the decoded controls, ex_rd=id_rd, ex_valid=1.
- A bubble sets all ex_* controls, ex_valid and ex_rd to 0.
- Stores and branches load ex_rd=id_rd, but their ex_regwrite=0.
- illegal <= id_valid & dec_illegal & ~flush & ~haz. One-cycle pulse, repeated each cycle the condition holds.
- Counters:
  - stall_cnt +1 per cycle with stall=1.
  - flush_cnt +1 per cycle with flush=1 and id_valid=1.
  - illegal_cnt +1 per illegal pulse.
  - Each counter saturates at all-ones and never wraps.
- Latency: decode to ex_* is exactly 1 cycle. A load-use stall lasts exactly 1 cycle, because the next cycle's EX slot holds the bubble, which clears haz.
- Simultaneous flush and haz: flush wins; stall=0, bubble inserted, stall_cnt unchanged.
- Reset asserted mid-stall: outputs clear immediately. After release the first instruction decodes normally with no residual stall.

Test Plan:
- Reset then single ops: R (01100) -> next cycle ex_regwrite=1, ex_aluop=10, ex_valid=1; load (00000) -> ex_memread=1, ex_memtoreg=1, ex_alusrc=1; store (01000) -> ex_memwrite=1, ex_regwrite=0; branch (11000) -> ex_branch=1, ex_aluop=01.
- Load-use: lw x5 then add x6,x5,x7 -> stall=1 for exactly 1 cycle, then a bubble in EX (ex_valid=0), then add enters EX, stall_cnt=1. The same sequence with rd=x0 -> no stall.
- JAL after lw x5, with id_rs1=5 -> no stall, because JAL does not use rs1. Sw x9,0(x5) after lw x5 -> stall asserted via rs1.
- Flush and hazard in the same cycle -> stall=0, bubble inserted, flush_cnt +1, stall_cnt unchanged.
- Opcode 10100 with id_valid=1 -> illegal pulse, ex_valid=0, illegal_cnt=1. With EN_JUMP=0, opcode 11011 -> illegal pulse.
- Force stall_cnt to 16'hFFFE, then 3 stalls -> stall_cnt holds at 16'hFFFF. Assert rst_n=0 mid-stall -> all outputs 0 without waiting for a clock edge.
